pwm_move_sequencer: RTL and testbench

Command-driven sequencer for the multi-channel servo PWM datapath of the cube-solving robot. It accepts move commands (channel, target duty in percent, hold time) over a valid/ready handshake, queues them, and drives one duty register per PWM channel. On each PWM period boundary it ramps the selected channel toward its target, then holds it for a programmed number of periods before starting the next command. The per-channel duty outputs feed the `D` inputs of the `pwm` instances; `period_tick` comes from the PWM period counter.

---
 rtl/pwm_seq_pkg.sv | 25 ++
 rtl/pwm_cmd_fifo.sv | 62 ++++++
 rtl/pwm_move_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pwm_move_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_pkg
// Brief    : Shared types and constants for the PWM move sequencer.
// Revision : 1.0
// ============================================================================
package pwm_seq_pkg;

    localparam int DUTY_MAX = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [7:0]  ch;
        logic [7:0]  duty;
        logic [15:0] hold;
    } seq_cmd_t;

endpackage
`default_nettype wire

// File: rtl/pwm_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cmd_fifo
// Brief    : Synchronous command FIFO; push is refused when full, pop when empty.
// Revision : 1.0
// ============================================================================
module pwm_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_move_sequencer
// Brief    : Queued servo move sequencer; ramps one PWM duty per command, then
//            holds. Define PWM_SEQ_RAMP_EN for STEP-limited ramping.
// Revision : 1.0
// ============================================================================
module pwm_move_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int STEP       = 2,
    parameter int DUTY_RST   = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [$clog2(NCH)-1:0]  cmd_ch,
    input  logic [7:0]              cmd_duty,
    input  logic [15:0]             cmd_hold,
    input  logic                    period_tick,
    output logic [NCH*8-1:0]        duty_o,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

`ifdef PWM_SEQ_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam int               CHW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int               STEP_LIM  = RAMP_EN ? STEP : DUTY_MAX;
    localparam logic signed [8:0] STEP_S   = 9'(STEP_LIM);
    localparam logic [7:0]       STEP8     = 8'(STEP_LIM);
    localparam logic [7:0]       DUTY_MAX8 = 8'(DUTY_MAX);
    localparam logic [7:0]       DUTY_RST8 = 8'(DUTY_RST);

    seq_state_t        state_q, state_d;
    seq_cmd_t          head_q, head_d;
    logic [CHW-1:0]    cur_ch_q, cur_ch_d;
    logic [7:0]        target_q, target_d;
    logic [15:0]       hold_q, hold_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic [7:0]        duty_q [NCH];
    logic [7:0]        duty_d [NCH];
    logic              done_q, done_d;
    logic              err_q, err_d;

    seq_cmd_t          push_cmd;
    seq_cmd_t          fifo_head;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        cur_duty;
    logic signed [8:0] diff;

    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign done      = done_q;
    assign err       = err_q;

    for (genvar k = 0; k < NCH; k++) begin : g_duty_out
        assign duty_o[8*k +: 8] = duty_q[k];
    end

    // Out-of-range duties are clipped before queueing so the datapath never sees them.
    always_comb begin
        push          = cmd_valid && !fifo_full;
        push_cmd.ch   = 8'(cmd_ch);
        push_cmd.duty = (cmd_duty > DUTY_MAX8) ? DUTY_MAX8 : cmd_duty;
        push_cmd.hold = cmd_hold;
        err_d         = push && (cmd_duty > DUTY_MAX8);
    end

    pwm_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(seq_cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_cmd),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        cur_ch_d   = cur_ch_q;
        target_d   = target_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        duty_d     = duty_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        cur_duty   = duty_q[cur_ch_q];
        diff       = $signed({1'b0, target_q}) - $signed({1'b0, cur_duty});

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    head_d  = fifo_head;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cur_ch_d = head_q.ch[CHW-1:0];
                target_d = head_q.duty;
                hold_d   = head_q.hold;
                // A command for a nonexistent channel completes without touching any duty.
                if (32'(head_q.ch) >= NCH) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (period_tick) begin
                    if ((diff <= STEP_S) && (diff >= -STEP_S)) begin
                        duty_d[cur_ch_q] = target_q;
                        if (hold_q != 16'd0) begin
                            hold_cnt_d = hold_q;
                            state_d    = HOLD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (diff > 9'sd0) begin
                        duty_d[cur_ch_q] = cur_duty + STEP8;
                    end else begin
                        duty_d[cur_ch_q] = cur_duty - STEP8;
                    end
                end
            end
            HOLD: begin
                if (period_tick) begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                    if (hold_cnt_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            cur_ch_q   <= '0;
            target_q   <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            duty_q     <= '{default: DUTY_RST8};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            cur_ch_q   <= cur_ch_d;
            target_q   <= target_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            duty_q     <= duty_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_move_sequencer
// Brief    : Directed self-checking bench for pwm_move_sequencer (NCH=4).
// Revision : 1.0
// ============================================================================
module tb_pwm_move_sequencer;

`ifdef PWM_SEQ_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [7:0]  cmd_duty;
    logic [15:0] cmd_hold;
    logic        period_tick;
    logic [31:0] duty_o;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_move_sequencer #(
        .NCH        (4),
        .FIFO_DEPTH (4),
        .STEP       (2),
        .DUTY_RST   (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_duty    (cmd_duty),
        .cmd_hold    (cmd_hold),
        .period_tick (period_tick),
        .duty_o      (duty_o),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
    endtask

    task automatic push(input int ch, input int duty, input int hold);
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_duty  = 8'(duty);
        cmd_hold  = 16'(hold);
        step();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [7:0] dch(input int k);
        return duty_o[8*k +: 8];
    endfunction

    initial begin
        int n;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_ch      = '0;
        cmd_duty    = '0;
        cmd_hold    = '0;
        period_tick = 1'b0;
        step();
        step();
        chk("rst_duty",  duty_o,    32'h32323232);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_err",   err,       0);
        rst = 1'b0;
        step();

        // ch1 -> 60 with a 3-period hold
        push(1, 60, 3);
        chk("t1_busy", busy, 1);
        step();
        step();
        n = RAMP ? 5 : 1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("t1_ramp_duty", dch(1), RAMP ? 50 + 2 * (i + 1) : 60);
            chk("t1_ramp_done", done, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_duty", dch(1), 60);
            chk("t1_hold_done", done, (i == 2) ? 1 : 0);
        end
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_busy",  busy, 0);
        chk("t1_others",     duty_o, 32'h32323C32);

        // X=(3,10,0) stalls in RAMP while four more commands fill the queue
        push(3, 10, 0);
        step();
        step();
        push(0, 150, 0);
        chk("q1_err",   err, 1);
        chk("q1_ready", cmd_ready, 1);
        push(2, 50, 0);
        chk("q2_err",   err, 0);
        chk("q2_ready", cmd_ready, 1);
        push(1, 70, 0);
        chk("q3_ready", cmd_ready, 1);
        push(0, 20, 5);
        chk("q4_ready", cmd_ready, 0);
        chk("q4_busy",  busy, 1);
        cmd_valid = 1'b1;
        cmd_ch    = 2'd3;
        cmd_duty  = 8'd90;
        cmd_hold  = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("q5_blocked", cmd_ready, 0);
        end
        n = RAMP ? 20 : 1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("x_duty", dch(3), RAMP ? 50 - 2 * (i + 1) : 10);
            chk("x_done", done, (i == n - 1) ? 1 : 0);
        end
        chk("x_full_at_done", cmd_ready, 0);
        step();
        chk("pop_edge_refuse", cmd_ready, 1);
        chk("pop_edge_done",   done, 0);
        step();
        cmd_valid = 1'b0;
        chk("q5_accept", cmd_ready, 0);

        // Q1: clipped 150 -> 100 on ch0
        n = RAMP ? 25 : 1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("q1_duty", dch(0), RAMP ? 50 + 2 * (i + 1) : 100);
            chk("q1_done", done, (i == n - 1) ? 1 : 0);
        end

        // Q2: target equals current duty
        step();
        step();
        tick();
        chk("q2_done", done, 1);
        chk("q2_duty", duty_o, 32'h0A323C64);

        // Q3 in RAMP with Q4, Q5 queued, then asynchronous reset
        step();
        step();
        chk("q3_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_duty",  duty_o,    32'h32323232);
        chk("arst_busy",  busy,      0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_done",  done,      0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        chk("post_rst_duty", duty_o, 32'h32323232);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
